// File: rtl/alarm_pkg.sv
// Shared types and default timing for the alarm siren controller.
// Holds the FSM state encoding and the counter-width helper used by the top.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SND_ON  = 2'd1,
    SND_OFF = 2'd2
  } alarm_state_e;

  localparam int DEF_BEEP_ON  = 4;
  localparam int DEF_BEEP_OFF = 4;
  localparam int DEF_TIMEOUT  = 64;

  // A counter that must hold 0..n-1 needs $clog2(n) bits, but never fewer than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registers a level input and flags the cycle where it goes from 0 to 1.
// The registered copy resets to 0, so a level already high at reset release counts as a rise.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/alarm_siren_ctrl.sv
// Alarm siren controller: starts a beeping episode on each alarm rise and ends it
// on operator ack or after TIMEOUT active cycles; counts episodes up to 255.
module alarm_siren_ctrl
  import alarm_pkg::*;
#(
  parameter int BEEP_ON  = DEF_BEEP_ON,
  parameter int BEEP_OFF = DEF_BEEP_OFF,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         alarm_bit,
  input  logic         ack,
  output logic         siren,
  output logic         alarm_active,
  output logic         timed_out,
  output logic [7:0]   event_count,
  output alarm_state_e dbg_state
);

  localparam int PH_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
  localparam int PW     = cnt_width(PH_MAX);
  localparam int AW     = cnt_width(TIMEOUT);

  localparam logic [PW-1:0] ON_LAST  = PW'(BEEP_ON - 1);
  localparam logic [PW-1:0] OFF_LAST = PW'(BEEP_OFF - 1);
  localparam logic [AW-1:0] ACT_LAST = AW'(TIMEOUT - 1);

  alarm_state_e  state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [AW-1:0] act_q, act_d;
  logic          timed_out_q, timed_out_d;
  logic [7:0]    count_q, count_d;
  logic          rise;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .d     (alarm_bit),
    .rise  (rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      act_q       <= '0;
      timed_out_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      act_q       <= act_d;
      timed_out_q <= timed_out_d;
      count_q     <= count_d;
    end
  end

  // Edge priority: rise, then ack, then timeout, then the beep-phase flip.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    act_d       = act_q;
    timed_out_d = timed_out_q;
    count_d     = count_q;
    if (rise) begin
      state_d     = SND_ON;
      phase_d     = '0;
      act_d       = '0;
      timed_out_d = 1'b0;
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
    end else begin
      case (state_q)
        IDLE: ;
        SND_ON, SND_OFF: begin
          if (ack) begin
            state_d = IDLE;
          end else if (act_q == ACT_LAST) begin
            state_d     = IDLE;
            timed_out_d = 1'b1;
          end else begin
            act_d = act_q + AW'(1);
            if (state_q == SND_ON && phase_q == ON_LAST) begin
              state_d = SND_OFF;
              phase_d = '0;
            end else if (state_q == SND_OFF && phase_q == OFF_LAST) begin
              state_d = SND_ON;
              phase_d = '0;
            end else begin
              phase_d = phase_q + PW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs come straight from registers so reset clears them without waiting for clk.
  assign siren        = (state_q == SND_ON);
  assign alarm_active = (state_q != IDLE);
  assign timed_out    = timed_out_q;
  assign event_count  = count_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// Self-checking bench for alarm_siren_ctrl with BEEP_ON=2, BEEP_OFF=3, TIMEOUT=20.
// Reference model tracks elapsed episode time and derives the siren with modular arithmetic.
module tb_alarm_siren_ctrl;
  import alarm_pkg::*;

  localparam int ON  = 2;
  localparam int OFF = 3;
  localparam int TO  = 20;

  // clock/reset block
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic alarm_bit = 1'b0;
  logic ack = 1'b0;
  logic siren, alarm_active, timed_out;
  logic [7:0] event_count;
  alarm_state_e dbg_state;

  always #5 clk = ~clk;

  alarm_siren_ctrl #(.BEEP_ON(ON), .BEEP_OFF(OFF), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .alarm_bit    (alarm_bit),
    .ack          (ack),
    .siren        (siren),
    .alarm_active (alarm_active),
    .timed_out    (timed_out),
    .event_count  (event_count),
    .dbg_state    (dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: episode described by elapsed active cycles
  logic m_active, m_to, m_prev;
  int   m_elapsed, m_cnt;
  logic [31:0] exp_q[$];

  task automatic model_reset();
    m_active = 0; m_to = 0; m_prev = 0; m_elapsed = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic a, input logic k);
    logic r;
    r = a && !m_prev;
    m_prev = a;
    if (r) begin
      m_active = 1; m_elapsed = 0; m_to = 0;
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    end else if (m_active && k) begin
      m_active = 0;
    end else if (m_active && m_elapsed == TO - 1) begin
      m_active = 0; m_to = 1;
    end else if (m_active) begin
      m_elapsed++;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic exp_siren;
    exp_siren = m_active && ((m_elapsed % (ON + OFF)) < ON);
    exp_q.push_back({30'd0, exp_siren, m_active});
    check({tag, ".siren"},  siren,        exp_siren);
    check({tag, ".active"}, alarm_active, m_active);
    check({tag, ".tout"},   timed_out,    m_to);
    check({tag, ".count"},  event_count,  m_cnt);
    void'(exp_q.pop_front());
  endtask

  // driver tasks
  int active_cycles;

  task automatic step(input logic a, input logic k, input string tag);
    alarm_bit = a;
    ack = k;
    @(posedge clk);
    model_edge(a, k);
    #1;
    check_outputs(tag);
    if (alarm_active) active_cycles++;
  endtask

  task automatic do_reset(input logic a);
    reset = 1'b1;
    alarm_bit = a;
    ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs("reset");
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset(1'b0);

    // single pulse, no ack: runs to timeout
    active_cycles = 0;
    step(1, 0, "pulse");
    for (int i = 0; i < 24; i++) step(0, 0, "pulse_run");
    check("pulse_active_len", active_cycles, TO);
    check("pulse_timed_out", timed_out, 1);
    check("pulse_count", event_count, 1);

    // pulse then ack at cycle 7
    step(1, 0, "ack_pulse");
    for (int i = 1; i < 7; i++) step(0, 0, "ack_run");
    step(0, 1, "ack_edge");
    check("ack_idle", alarm_active, 0);
    check("ack_tout", timed_out, 0);
    for (int i = 0; i < 3; i++) step(0, 0, "ack_after");

    // second pulse at cycle 10 restarts the episode
    step(1, 0, "re_pulse1");
    for (int i = 1; i < 10; i++) step(0, 0, "re_run1");
    active_cycles = 0;
    step(1, 0, "re_pulse2");
    check("re_siren", siren, 1);
    for (int i = 0; i < 24; i++) step(0, 0, "re_run2");
    check("re_active_len", active_cycles, TO);

    // rise and ack on the same edge while active
    step(1, 0, "ra_pulse");
    for (int i = 0; i < 4; i++) step(0, 0, "ra_run");
    step(1, 1, "ra_both");
    check("ra_state", dbg_state, SND_ON);
    for (int i = 0; i < 3; i++) step(0, 0, "ra_after");

    // alarm held high for 50 cycles: one episode only
    do_reset(1'b0);
    active_cycles = 0;
    for (int i = 0; i < 50; i++) step(1, 0, "hold");
    check("hold_active_len", active_cycles, TO);
    check("hold_count", event_count, 1);
    check("hold_tout", timed_out, 1);
    step(0, 0, "hold_release");

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 4), "rand");

    // 300 pulses saturate the episode counter
    do_reset(1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1, 0, "sat_hi");
      step(0, 0, "sat_lo");
    end
    check("sat_count", event_count, 255);

    // reset mid-SND_ON between edges; alarm held high across release
    do_reset(1'b0);
    step(1, 0, "mid_pulse");
    check("mid_siren_before", siren, 1);
    #3;
    reset = 1'b1;
    #1;
    check("mid_siren_async", siren, 0);
    check("mid_active_async", alarm_active, 0);
    check("mid_tout_async", timed_out, 0);
    check("mid_count_async", event_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1, 0, "release_rise");
    check("release_count", event_count, 1);
    for (int i = 0; i < 5; i++) step(1, 0, "release_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_siren_ctrl.md
ALARM_SIREN_CTRL -- requirements
Module: alarm_siren_ctrl

Interface
REQ-001 Parameter BEEP_ON, default 4: cycles the siren is high per beep period.
REQ-002 Parameter BEEP_OFF, default 4: cycles the siren is low per beep period.
REQ-003 Parameter TIMEOUT, default 64: maximum active cycles before auto-silence; SHALL be > BEEP_ON+BEEP_OFF.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 alarm_bit  input  1  level alarm from the upstream sequence-detector FSM; synchronous to clk.
REQ-007 ack  input  1  operator acknowledge, level, synchronous to clk.
REQ-008 siren  output  1  beep-modulated siren drive.
REQ-009 alarm_active  output  1  high while an alarm episode is in progress.
REQ-010 timed_out  output  1  sticky flag: the last episode ended by timeout.
REQ-011 event_count  output  8  number of alarm episodes started since reset, saturating.

Function
REQ-012 SHALL register alarm_bit each cycle; a rise = alarm_bit==1 with registered previous value ==0.
REQ-013 FSM states SHALL be IDLE, SND_ON, SND_OFF.
REQ-014 IDLE: on rise, go to SND_ON, clear phase and active-time counters, clear timed_out, increment event_count; otherwise stay.
REQ-015 SND_ON: after BEEP_ON cycles in the state, go to SND_OFF; SND_OFF: after BEEP_OFF cycles, go to SND_ON.
REQ-016 The active-time counter SHALL increment every cycle in SND_ON/SND_OFF; when it reaches TIMEOUT-1, go to IDLE and set timed_out.
REQ-017 ack==1 in SND_ON/SND_OFF SHALL go to IDLE on the next edge; timed_out unchanged.
REQ-018 A rise in SND_ON/SND_OFF SHALL restart the episode: go to SND_ON, clear both counters, increment event_count.
REQ-019 Priority on the same edge: rise > ack > timeout > beep-phase transition.
REQ-020 siren SHALL equal (state==SND_ON); alarm_active SHALL equal (state!=IDLE); both decoded from the state register, no input-to-output combinational path.
REQ-021 Latency: a rise sampled at edge k SHALL give siren=1 and alarm_active=1 after edge k.
REQ-022 event_count SHALL saturate at 255, never wrap.
REQ-023 alarm_bit held high with no new rise SHALL NOT restart or extend an episode.
REQ-024 Counters SHALL be sized $clog2 of their parameter and SHALL NOT overflow for any legal parameter value.

Reset
REQ-025 reset SHALL asynchronously force state=IDLE, siren=0, alarm_active=0, timed_out=0, event_count=0, counters=0, registered alarm_bit=0.
REQ-026 reset asserted mid-episode SHALL drop siren within the same cycle, with no wait for clk.
REQ-027 alarm_bit already high at reset release SHALL count as a rise on the first edge.

Structure
REQ-028 Package alarm_pkg SHALL hold the state enum type and the default BEEP_ON, BEEP_OFF, TIMEOUT values.
REQ-029 Rise detection SHALL be a sub-module rise_detect (clk, reset, d, rise).
REQ-030 The FSM and the counters SHALL live in alarm_siren_ctrl.

Verification (BEEP_ON=2, BEEP_OFF=3, TIMEOUT=20)
REQ-031 Single-cycle pulse on alarm_bit, no ack -> siren pattern 1,1,0,0,0 repeated; alarm_active=1 for exactly 20 cycles; then timed_out=1, event_count=1.
REQ-032 Pulse, then ack at cycle 7 -> IDLE at cycle 8, siren=0, timed_out=0.
REQ-033 Second pulse at cycle 10 of an episode -> siren restarts with 1,1 and the episode ends 20 cycles after the second pulse; event_count=2.
REQ-034 Rise and ack on the same edge while active -> episode restarts (SND_ON), event_count incremented.
REQ-035 alarm_bit held high for 50 cycles -> exactly one episode, timeout after 20 cycles, event_count=1.
REQ-036 300 separate pulses -> event_count=255; reset asserted mid-SND_ON between edges -> siren=0 immediately, all outputs 0.
